// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM states,
// counter sizing and the divide-by-zero quotient fill value.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // The step counter counts down from WIDTH-1 to 0.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  // A zero divisor yields a quotient with every bit set to this value.
  localparam logic DBZ_Q_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of the divider: operands and tag in, result and tag out,
// with a valid/ready handshake on each side.
interface seq_divider_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic [TAG_W-1:0] out_tag;
  logic             out_div_by_zero;

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_tag, out_div_by_zero
  );

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_tag, out_div_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);
  logic [WIDTH:0] shifted_d;
  logic [WIDTH:0] trial_d;

  // The partial remainder is always below the divisor, so WIDTH+1 bits hold the shifted value.
  assign shifted_d = {rem_i, bit_i};
  assign trial_d   = shifted_d - {1'b0, divisor_i};
  assign qbit_o    = ~trial_d[WIDTH];
  assign rem_o     = qbit_o ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned integer divider: one quotient bit per cycle on
// magnitudes, sign fix-up in a final cycle, registered result with backpressure.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  output logic         busy,
  seq_divider_if.slave io
);
  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] dvd_q;       // remaining dividend bits, quotient bits shift in at the bottom
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] orig_dvd_q;
  logic [TAG_W-1:0] tag_q;
  logic             qsign_q;
  logic             rsign_q;
  logic             dbz_q;

  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic [TAG_W-1:0] tag_out_q;
  logic             dbz_out_q;

  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;
  logic             accept;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign io.in_ready = (state_q == S_IDLE) || (state_q == S_DONE && io.out_ready);
  assign accept      = io.in_valid && io.in_ready && !flush;
  assign busy        = (state_q != S_IDLE);

  assign io.out_valid       = (state_q == S_DONE);
  assign io.out_quotient    = quo_out_q;
  assign io.out_remainder   = rem_out_q;
  assign io.out_tag         = tag_out_q;
  assign io.out_div_by_zero = dbz_out_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (prem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .qbit_o    (qbit_d)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      tag_out_q <= '0;
      dbz_out_q <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_CALC;
            cnt_q   <= CNT_W'(WIDTH - 1);
          end
        end
        S_CALC: begin
          if (cnt_q == '0) state_q <= S_FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_FIX: begin
          // Divide by zero overrides the sign-corrected result.
          if (dbz_q) begin
            quo_out_q <= {WIDTH{DBZ_Q_BIT}};
            rem_out_q <= orig_dvd_q;
          end else begin
            quo_out_q <= cond_negate(dvd_q, qsign_q);
            rem_out_q <= cond_negate(prem_q, rsign_q);
          end
          tag_out_q <= tag_q;
          dbz_out_q <= dbz_q;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          if (io.out_ready) begin
            if (accept) begin
              state_q <= S_CALC;
              cnt_q   <= CNT_W'(WIDTH - 1);
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operand datapath: loaded on accept, shifted every CALC cycle; control state guards its use.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q      <= magnitude(io.in_dividend, io.in_signed);
      dvs_q      <= magnitude(io.in_divisor, io.in_signed);
      prem_q     <= '0;
      orig_dvd_q <= io.in_dividend;
      tag_q      <= io.in_tag;
      qsign_q    <= io.in_signed && (io.in_dividend[WIDTH-1] ^ io.in_divisor[WIDTH-1]);
      rsign_q    <= io.in_signed && io.in_dividend[WIDTH-1];
      dbz_q      <= (io.in_divisor == '0);
    end else if (state_q == S_CALC) begin
      prem_q <= rem_d;
      dvd_q  <= {dvd_q[WIDTH-2:0], qbit_d};
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized bench for seq_divider (WIDTH=32) against an
// arithmetic reference model.
module tb_seq_divider;
  localparam int W  = 32;
  localparam int TW = 5;

  logic clk;
  logic resetn;
  logic flush;
  logic busy;

  seq_divider_if #(.WIDTH(W), .TAG_W(TW)) io ();

  seq_divider #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .busy   (busy),
    .io     (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
  endtask

  // Reference: plain integer division with truncation toward zero.
  task automatic model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic drive_req(input bit sg, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
    io.in_valid    = 1'b1;
    io.in_signed   = sg;
    io.in_dividend = a;
    io.in_divisor  = b;
    io.in_tag      = tg;
  endtask

  // After the accepting edge, count edges until out_valid is seen at a falling edge.
  task automatic wait_result(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (io.out_valid) break;
    end
  endtask

  task automatic check_result(input string nm, input bit sg, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] tg, input int n);
    logic [31:0] eq, er;
    model(sg, a, b, eq, er);
    chk({nm, "_lat"}, 64'(n), 64'd33);
    chk({nm, "_vld"}, 64'(io.out_valid), 64'd1);
    chk({nm, "_q"},   64'(io.out_quotient), 64'(eq));
    chk({nm, "_r"},   64'(io.out_remainder), 64'(er));
    chk({nm, "_tag"}, 64'(io.out_tag), 64'(tg));
    chk({nm, "_dbz"}, 64'(io.out_div_by_zero), 64'(b == 32'd0));
  endtask

  // Starts at a falling edge; returns at the falling edge where the result is visible.
  task automatic run_op(input string nm, input bit sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg);
    int n;
    drive_req(sg, a, b, tg);
    #1;
    n = 0;
    while (!io.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_inrdy"}, 64'(io.in_ready), 64'd1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    wait_result(n);
    check_result(nm, sg, a, b, tg, n);
  endtask

  initial begin
    logic [31:0] hq, hr, ra, rb;
    logic [4:0]  htag, rt;
    bit          rs;
    bit          seen;
    int          n;

    resetn = 1'b0;
    flush  = 1'b0;
    io.in_valid = 1'b0; io.in_signed = 1'b0; io.in_dividend = '0;
    io.in_divisor = '0; io.in_tag = '0; io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_in_ready",  64'(io.in_ready), 64'd1);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_q",         64'(io.out_quotient), 64'd0);
    chk("rst_r",         64'(io.out_remainder), 64'd0);
    chk("rst_tag",       64'(io.out_tag), 64'd0);
    chk("rst_dbz",       64'(io.out_div_by_zero), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_op("u100_7",   1'b0, 32'd100, 32'd7, 5'd5);
    chk("u100_7_q_const", 64'(io.out_quotient), 64'd14);
    chk("u100_7_r_const", 64'(io.out_remainder), 64'd2);
    run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 5'd1);
    chk("s_m7_2_q_const", 64'(io.out_quotient), 64'hFFFF_FFFD);
    chk("s_m7_2_r_const", 64'(io.out_remainder), 64'hFFFF_FFFF);
    run_op("s_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 5'd2);
    chk("s_7_m2_r_const", 64'(io.out_remainder), 64'd1);
    run_op("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    chk("s_ovf_q_const", 64'(io.out_quotient), 64'h8000_0000);
    run_op("u_big",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    chk("u_big_r_const", 64'(io.out_remainder), 64'h8000_0000);
    run_op("s_dbz",    1'b1, 32'd5, 32'd0, 5'd6);
    run_op("u_dbz",    1'b0, 32'd5, 32'd0, 5'd7);
    chk("u_dbz_q_const", 64'(io.out_quotient), 64'hFFFF_FFFF);

    // Flush ten edges into an operation.
    drive_req(1'b0, 32'd1000, 32'd3, 5'd9);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy",     64'(busy), 64'd0);
    chk("flush_in_ready", 64'(io.in_ready), 64'd1);
    flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (io.out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    run_op("after_flush", 1'b0, 32'd9, 32'd3, 5'd10);

    // Reset in the middle of an operation acts like a flush.
    drive_req(1'b1, 32'd77, 32'd5, 5'd11);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_busy",  64'(busy), 64'd0);
    chk("midrst_valid", 64'(io.out_valid), 64'd0);
    chk("midrst_q",     64'(io.out_quotient), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Backpressure: hold the result for five cycles.
    io.out_ready = 1'b0;
    drive_req(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd12);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    wait_result(n);
    check_result("bp", 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd12, n);
    hq = io.out_quotient; hr = io.out_remainder; htag = io.out_tag;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(io.out_valid), 64'd1);
      chk("bp_hold_q",     64'(io.out_quotient), 64'(hq));
      chk("bp_hold_r",     64'(io.out_remainder), 64'(hr));
      chk("bp_hold_tag",   64'(io.out_tag), 64'(htag));
      chk("bp_in_ready",   64'(io.in_ready), 64'd0);
    end
    io.out_ready = 1'b1;
    run_op("b2b", 1'b0, 32'd12345, 32'd100, 5'd13);

    // Randomized operations, back-to-back with out_ready high.
    for (int k = 0; k < 24; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'd0 - 32'($urandom_range(1, 15));
        3:       rb = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (k == 5) ra = 32'h8000_0000;
      rt = 5'($urandom);
      run_op("rand", rs, ra, rb, rt);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
